// File: rtl/dsp_meter_pkg.sv
// Shared types and helpers for the DSP frequency-meter blocks.
package dsp_meter_pkg;

    // Measurement FSM states
    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        REPORT
    } meter_state_e;

    // Default edge-count width
    localparam int unsigned CNT_W_DEF = 16;

    // Counter width able to hold 0..n-1; never narrower than one bit
    function automatic int unsigned gate_cnt_w(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
// Rise on i_din to o_pulse high is three clk cycles.
module sync_rise_det (
    input  logic clk,
    input  logic rst,
    input  logic i_din,
    output logic o_pulse
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_pulse;

    // Synchronise the asynchronous input and register a one-cycle rise pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= i_din;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_pulse <= r_sync & ~r_prev;
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/vco_freq_meter.sv
// VCO frequency meter: counts synchronised VCO rising edges over a fixed gate
// window, reports count and signed error against target, and flags lock.
module vco_freq_meter
    import dsp_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES  = 1000,
    parameter int unsigned CNT_W        = CNT_W_DEF,
    parameter int unsigned TOL          = 2,
    parameter int unsigned LOCK_WINDOWS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vco_in,
    input  logic             enable,
    input  logic [CNT_W-1:0] target,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W:0]   freq_err,
    output logic             count_valid,
    output logic             overflow,
    output logic             locked
);

    localparam int unsigned GW = gate_cnt_w(GATE_CYCLES);
    localparam int unsigned LW = gate_cnt_w(LOCK_WINDOWS + 1);

    localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [LW-1:0]    LOCK_MAX  = LW'(LOCK_WINDOWS);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);

    meter_state_e     r_state;
    logic [GW-1:0]    r_gate;
    logic [CNT_W-1:0] r_edge_cnt;
    logic             r_ovf_win;
    logic [LW-1:0]    r_lock_cnt;

    logic             w_edge;
    logic [CNT_W:0]   w_err;
    logic [CNT_W:0]   w_abs;
    logic             w_in_tol;
    logic [LW-1:0]    w_lock_next;

    sync_rise_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_din   (vco_in),
        .o_pulse (w_edge)
    );

    // Zero-extended operands keep the difference from wrapping
    assign w_err       = {1'b0, r_edge_cnt} - {1'b0, target};
    assign w_abs       = w_err[CNT_W] ? ((CNT_W + 1)'(0) - w_err) : w_err;
    assign w_in_tol    = (w_abs <= TOL_V) && !r_ovf_win;
    assign w_lock_next = !w_in_tol ? '0 :
                         (r_lock_cnt == LOCK_MAX) ? LOCK_MAX : r_lock_cnt + LW'(1);

    // Measurement FSM with counters and registered report outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_gate      <= '0;
            r_edge_cnt  <= '0;
            r_ovf_win   <= 1'b0;
            r_lock_cnt  <= '0;
            count       <= '0;
            freq_err    <= '0;
            count_valid <= 1'b0;
            overflow    <= 1'b0;
            locked      <= 1'b0;
        end else begin
            count_valid <= 1'b0;
            if (!enable) begin
                // Partial window dropped; report registers hold, lock is lost
                r_state    <= IDLE;
                r_gate     <= '0;
                r_edge_cnt <= '0;
                r_ovf_win  <= 1'b0;
                r_lock_cnt <= '0;
                locked     <= 1'b0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        r_gate     <= '0;
                        r_edge_cnt <= '0;
                        r_ovf_win  <= 1'b0;
                        r_state    <= MEASURE;
                    end
                    MEASURE: begin
                        if (w_edge) begin
                            if (r_edge_cnt == CNT_MAX) begin
                                r_ovf_win <= 1'b1;
                            end else begin
                                r_edge_cnt <= r_edge_cnt + CNT_W'(1);
                            end
                        end
                        if (r_gate == GATE_LAST) begin
                            r_gate  <= '0;
                            r_state <= REPORT;
                        end else begin
                            r_gate <= r_gate + GW'(1);
                        end
                    end
                    REPORT: begin
                        // Edge pulses in this dead cycle are discarded
                        count       <= r_edge_cnt;
                        freq_err    <= w_err;
                        overflow    <= r_ovf_win;
                        count_valid <= 1'b1;
                        r_lock_cnt  <= w_lock_next;
                        locked      <= (w_lock_next == LOCK_MAX);
                        r_gate      <= '0;
                        r_edge_cnt  <= '0;
                        r_ovf_win   <= 1'b0;
                        r_state     <= MEASURE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
